// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter slice.
package mod_counter_pkg;

  // Encoding of the DIR input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_if.sv
// Control/status bundle of the modulo counter: count enable, direction,
// load, terminal value, prescale and the registered results.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned PRE_W = 8
);

  logic             T;
  logic             DIR;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] MAX;
  logic [PRE_W-1:0] DIV;
  logic             CLR_WRAP;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;

  // Side that drives the counter controls and observes its outputs.
  modport master (
    output T, DIR, LD, D, MAX, DIV, CLR_WRAP,
    input  Q, TC, WRAP
  );

  // The counter itself.
  modport slave (
    input  T, DIR, LD, D, MAX, DIV, CLR_WRAP,
    output Q, TC, WRAP
  );

endinterface : mod_counter_if

// File: rtl/mod_prescaler.sv
// Clock-enable prescaler: issues one STEP every DIV+1 enabled cycles.
module mod_prescaler #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             CLR,
  input  logic             T,
  input  logic [PRE_W-1:0] DIV,
  output logic             STEP
);

  logic [PRE_W-1:0] p_q;
  logic [PRE_W-1:0] p_d;
  logic             hit;

  // A step fires once the phase reaches DIV; using >= lets a DIV lowered
  // below the current phase take effect on the very next enabled cycle.
  assign hit  = (p_q >= DIV);
  assign STEP = T & hit;

  // Phase next-state: hold while disabled, restart on a step.
  always_comb begin
    p_d = p_q;
    if (T) begin
      if (hit) begin
        p_d = '0;
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  // Phase register; reset and load both restart the phase.
  always_ff @(posedge C) begin
    if (R) begin
      p_q <= '0;
    end else if (CLR) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule : mod_prescaler

// File: rtl/mod_counter.sv
// Up/down modulo counter with parallel load, programmable terminal value,
// prescaled count enable, terminal-count pulse and sticky wrap flag.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned PRE_W = 8
) (
  input  logic        C,
  input  logic        R,
  mod_counter_if.slave bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             step;
  logic             wrap_evt;

  mod_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .C    (C),
    .R    (R),
    .CLR  (bus.LD),
    .T    (bus.T),
    .DIV  (bus.DIV),
    .STEP (step)
  );

  // Counter next-state: load (clamped to MAX) beats a count step, else hold.
  always_comb begin
    q_d      = q_q;
    wrap_evt = 1'b0;
    if (bus.LD) begin
      q_d = (bus.D > bus.MAX) ? bus.MAX : bus.D;
    end else if (step) begin
      unique case (bus.DIR)
        DIR_UP: begin
          if (q_q >= bus.MAX) begin
            q_d      = '0;
            wrap_evt = 1'b1;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
        DIR_DOWN: begin
          // Out-of-range value (MAX lowered under Q) snaps to MAX silently.
          if (q_q == '0) begin
            q_d      = bus.MAX;
            wrap_evt = 1'b1;
          end else if (q_q > bus.MAX) begin
            q_d = bus.MAX;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
      endcase
    end
  end

  // Flag next-state: TC mirrors the wrap event; a new wrap beats CLR_WRAP.
  always_comb begin
    tc_d   = wrap_evt;
    wrap_d = wrap_evt | (wrap_q & ~bus.CLR_WRAP);
  end

  // State registers with synchronous reset.
  always_ff @(posedge C) begin
    if (R) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.TC   = tc_q;
  assign bus.WRAP = wrap_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed scenarios then random traffic,
// checked against a behavioural model of the counting rules.
module tb_mod_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;

  typedef struct {
    int q;
    bit tc;
    bit wr;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sbq[$];
  int   total;
  int   bad;

  // Reference model state (plain integers).
  int m_q;
  int m_phase;
  bit m_wr;

  mod_counter_if #(.WIDTH(W), .PRE_W(PW)) bus ();

  mod_counter #(
    .WIDTH (W),
    .PRE_W (PW)
  ) dut (
    .C   (clk),
    .R   (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the counter rules to the inputs that will be sampled at the next
  // edge, queue the expected outputs, then advance one cycle.
  task automatic tick();
    exp_t e;
    bit   stepped;
    bit   wevt;
    int   mx;
    mx      = int'(bus.MAX);
    stepped = 0;
    wevt    = 0;
    if (rst) begin
      m_q = 0; m_phase = 0; m_wr = 0;
    end else if (bus.LD) begin
      m_q     = (int'(bus.D) > mx) ? mx : int'(bus.D);
      m_phase = 0;
      m_wr    = m_wr && !bus.CLR_WRAP;
    end else begin
      if (bus.T) begin
        if (m_phase >= int'(bus.DIV)) begin
          stepped = 1; m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      if (stepped) begin
        if (bus.DIR) begin
          if (m_q >= mx) begin m_q = 0; wevt = 1; end
          else m_q = m_q + 1;
        end else begin
          if (m_q == 0) begin m_q = mx; wevt = 1; end
          else if (m_q > mx) m_q = mx;
          else m_q = m_q - 1;
        end
      end
      m_wr = wevt || (m_wr && !bus.CLR_WRAP);
    end
    e.q  = m_q;
    e.tc = wevt;
    e.wr = m_wr;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set(input bit t, input bit dir, input int mx, input int dv);
    bus.T   = t;
    bus.DIR = dir;
    bus.MAX = W'(mx);
    bus.DIV = PW'(dv);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  task automatic load(input int d);
    bus.LD = 1'b1;
    bus.D  = W'(d);
    tick();
    bus.LD = 1'b0;
  endtask

  // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("Q", int'(bus.Q), e.q);
        check("TC", int'(bus.TC), int'(e.tc));
        check("WRAP", int'(bus.WRAP), int'(e.wr));
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    m_q = 0; m_phase = 0; m_wr = 0;
    rst = 1'b1;
    bus.LD = 1'b0; bus.D = '0; bus.CLR_WRAP = 1'b0;
    set(1'b1, 1'b1, 9, 0);

    // Up count 0..9 then wrap to 0.
    do_reset(2);
    run(13);

    // Down count: first step wraps 0->9 while CLR_WRAP is asserted.
    set(1'b1, 1'b0, 9, 0);
    do_reset(1);
    bus.CLR_WRAP = 1'b1;
    tick();
    bus.CLR_WRAP = 1'b0;
    run(3);
    bus.CLR_WRAP = 1'b1;
    tick();
    bus.CLR_WRAP = 1'b0;
    run(2);

    // Prescale by 4, pause for 5 cycles, resume with phase intact.
    set(1'b1, 1'b1, 200, 3);
    do_reset(1);
    run(10);
    bus.T = 1'b0;
    run(5);
    bus.T = 1'b1;
    run(10);

    // Load clamp, load restarting the phase, load together with T.
    set(1'b1, 1'b1, 15, 3);
    load(20);
    run(3);
    load(5);
    run(9);

    // MAX lowered under Q: up wraps to 0, down snaps to MAX.
    set(1'b1, 1'b1, 15, 0);
    load(12);
    set(1'b1, 1'b1, 7, 0);
    tick();
    set(1'b1, 1'b0, 15, 0);
    load(12);
    set(1'b1, 1'b0, 7, 0);
    run(2);

    // Full-range roll-over with MAX all-ones.
    set(1'b1, 1'b1, 255, 0);
    load(252);
    run(5);

    // Reset while counting with LD high, then phase restarts from 0.
    set(1'b1, 1'b1, 100, 5);
    load(40);
    run(8);
    bus.LD = 1'b1; bus.D = W'(33);
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.LD = 1'b0;
    run(8);

    // MAX=0: Q stays 0, every step wraps.
    set(1'b1, 1'b1, 0, 1);
    run(6);
    bus.DIR = 1'b0;
    run(4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      bus.LD      = ($urandom_range(0, 99) < 8);
      bus.D       = W'($urandom);
      bus.T       = ($urandom_range(0, 99) < 80);
      bus.DIR     = W'($urandom) > 8'd100;
      bus.CLR_WRAP = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 10) begin
        case ($urandom_range(0, 3))
          0:       bus.MAX = '0;
          1:       bus.MAX = '1;
          2:       bus.MAX = W'($urandom);
          default: bus.MAX = W'($urandom_range(1, 12));
        endcase
      end
      if ($urandom_range(0, 99) < 5) bus.DIV = PW'($urandom_range(0, 4));
      tick();
    end
    rst = 1'b0; bus.LD = 1'b0; bus.CLR_WRAP = 1'b0;

    // Drain: every queued expectation must have been consumed.
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_counter
